// File: rtl/uart_wb_initiator.sv
// rtl/uart_wb_initiator.sv - Wishbone initiator exposing a SiFive-layout UART as TX/RX byte streams
// Optional RX path enabled by defining UART_INITIATOR_RX_EN.
module uart_wb_initiator #(
    parameter int unsigned CLOCK_FREQ_HZ = 10000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned DIV_INIT      = CLOCK_FREQ_HZ / BAUD_RATE - 1,
    parameter bit          NSTOP         = 1'b0,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [2:0]  ADR_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        bus_error
);

`ifdef UART_INITIATOR_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    localparam logic [2:0]  ADR_TXDATA = 3'd0;
    localparam logic [2:0]  ADR_RXDATA = 3'd1;
    localparam logic [2:0]  ADR_TXCTRL = 3'd2;
    localparam logic [2:0]  ADR_RXCTRL = 3'd3;
    localparam logic [2:0]  ADR_DIV    = 3'd6;
    localparam logic [15:0] TO_LAST    = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        INIT_DIV, INIT_TXCTRL, INIT_RXCTRL, IDLE, TX_POLL, TX_WRITE, RX_POLL
    } state_t;

    state_t      state, state_n;
    logic [15:0] to_cnt, to_cnt_n;
    logic        cyc_n, we_n;
    logic [2:0]  adr_n;
    logic [31:0] dat_n;
    logic [7:0]  tx_byte, tx_byte_n;
    logic        tx_ready_n, bus_error_n, init_done_n;
    logic        last_served, last_served_n;
    logic        rx_valid_q;
    logic [7:0]  rx_data_q;
    logic        ack, timeout;

    assign STB_O   = CYC_O;
    assign ack     = CYC_O & ACK_I;
    // Expires on the edge that would bring the wait count to ACK_TIMEOUT.
    assign timeout = CYC_O & ~ACK_I & (to_cnt == TO_LAST);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state     <= INIT_DIV;
            CYC_O     <= 1'b0;
            WE_O      <= 1'b0;
            ADR_O     <= 3'd0;
            DAT_O     <= 32'd0;
            to_cnt    <= 16'd0;
            tx_byte   <= 8'd0;
            tx_ready  <= 1'b0;
            bus_error <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            CYC_O     <= cyc_n;
            WE_O      <= we_n;
            ADR_O     <= adr_n;
            DAT_O     <= dat_n;
            to_cnt    <= to_cnt_n;
            tx_byte   <= tx_byte_n;
            tx_ready  <= tx_ready_n;
            bus_error <= bus_error_n;
            init_done <= init_done_n;
        end
    end

    always_comb begin
        state_n       = state;
        last_served_n = last_served;
        tx_byte_n     = tx_byte;
        case (state)
            INIT_DIV:    if (ack) state_n = INIT_TXCTRL;
            INIT_TXCTRL: if (ack) state_n = INIT_RXCTRL;
            INIT_RXCTRL: if (ack) state_n = IDLE;
            IDLE: begin
                // last_served=1 means RX went last, so TX wins a tie.
                if (RX_EN && !rx_valid_q && (!tx_valid || !last_served)) begin
                    state_n       = RX_POLL;
                    last_served_n = 1'b1;
                end else if (tx_valid) begin
                    state_n       = TX_POLL;
                    last_served_n = 1'b0;
                end
            end
            TX_POLL: begin
                if (ack) begin
                    if (DAT_I[31]) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = TX_WRITE;
                        tx_byte_n = tx_data;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                end
            end
            TX_WRITE, RX_POLL: if (ack || timeout) state_n = IDLE;
            default: state_n = INIT_DIV;
        endcase
    end

    always_comb begin
        cyc_n    = CYC_O;
        we_n     = WE_O;
        adr_n    = ADR_O;
        dat_n    = DAT_O;
        to_cnt_n = 16'd0;
        if (CYC_O) begin
            if (ack || timeout) begin
                cyc_n = 1'b0;
                we_n  = 1'b0;
                adr_n = 3'd0;
                dat_n = 32'd0;
            end else begin
                to_cnt_n = to_cnt + 16'd1;
            end
        end else if (state != IDLE) begin
            cyc_n = 1'b1;
            case (state)
                INIT_DIV:    begin we_n = 1'b1; adr_n = ADR_DIV;    dat_n = {16'b0, 16'(DIV_INIT)}; end
                INIT_TXCTRL: begin we_n = 1'b1; adr_n = ADR_TXCTRL; dat_n = {30'b0, NSTOP, 1'b1};   end
                INIT_RXCTRL: begin we_n = 1'b1; adr_n = ADR_RXCTRL; dat_n = {31'b0, RX_EN};         end
                TX_POLL:     begin we_n = 1'b0; adr_n = ADR_TXDATA; dat_n = 32'd0;                  end
                TX_WRITE:    begin we_n = 1'b1; adr_n = ADR_TXDATA; dat_n = {24'b0, tx_byte};       end
                RX_POLL:     begin we_n = 1'b0; adr_n = ADR_RXDATA; dat_n = 32'd0;                  end
                default:     cyc_n = 1'b0;
            endcase
        end
        tx_ready_n  = (state == TX_WRITE) && ack;
        bus_error_n = timeout;
        init_done_n = init_done || ((state == INIT_RXCTRL) && ack);
    end

`ifdef UART_INITIATOR_RX_EN
    // A poll is only issued with the holding register empty, so load and clear never collide.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            last_served <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'd0;
        end else begin
            last_served <= last_served_n;
            if ((state == RX_POLL) && ack && !DAT_I[31]) begin
                rx_data_q  <= DAT_I[7:0];
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    logic unused_dat;
    assign unused_dat = &{1'b0, DAT_I[30:8]};
`else
    assign last_served = 1'b0;
    assign rx_valid_q  = 1'b0;
    assign rx_data_q   = 8'd0;

    logic unused_rx;
    assign unused_rx = &{1'b0, DAT_I[30:0], rx_ready, last_served_n};
`endif

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_uart_wb_initiator.sv
// tb/tb_uart_wb_initiator.sv - directed bench for uart_wb_initiator with a 1-cycle-ACK slave
module tb_uart_wb_initiator;
    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic        CYC_O, STB_O, WE_O, ACK_I;
    logic [2:0]  ADR_O;
    logic [31:0] DAT_O, DAT_I;
    logic [7:0]  tx_data  = 8'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        init_done, bus_error;

    logic        ack_en     = 1'b0;
    logic [31:0] rx_word    = 32'h8000_0000;
    int          tx_polls   = 0;
    int          full_until = 0;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] log_q[$];
    int          gap_err = 0, tx_ready_cnt = 0, bus_err_cnt = 0, rx_reads = 0, rx_seen = 0;
    logic        prev_ack = 1'b0;

    uart_wb_initiator #(.ACK_TIMEOUT(4)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done), .bus_error(bus_error)
    );

    always #5 CLK_I = ~CLK_I;

    assign ACK_I = CYC_O & STB_O & ack_en;
    assign DAT_I = (ADR_O == 3'd0) ? {(tx_polls < full_until), 31'b0} :
                   (ADR_O == 3'd1) ? rx_word : 32'h0;

    always @(posedge CLK_I)
        if (CYC_O && ACK_I && !WE_O && ADR_O == 3'd0) tx_polls <= tx_polls + 1;

    always @(negedge CLK_I) begin
        if (CYC_O && ACK_I) begin
            log_q.push_back({WE_O, ADR_O, DAT_O});
            if (!WE_O && ADR_O == 3'd1) rx_reads++;
        end
        if (CYC_O && prev_ack) gap_err++;
        prev_ack = CYC_O && ACK_I;
        if (tx_ready) tx_ready_cnt++;
        if (bus_error) bus_err_cnt++;
        if (rx_valid || rx_data != 8'd0) rx_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK_I);
        #1;
    endtask

    function automatic logic [35:0] entry(input logic [35:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return '1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base, lat, stb_cycles, be0, rdy0, rd0, n_rd, n_wr, alt_err, last_adr, stop;
        logic [35:0] tq[$];

        repeat (3) tick();
        check("rst_ctl", 64'({CYC_O, STB_O, WE_O, tx_ready, rx_valid, init_done, bus_error}), 64'd0);
        check("rst_dat", 64'({ADR_O, DAT_O, rx_data}), 64'd0);

        // Slave silent: watch the first init write time out and retry.
        RST_I = 1'b1;
        for (int i = 0; i < 20 && !STB_O; i++) tick();
        check("to_start", 64'({STB_O, WE_O, ADR_O, DAT_O}), 64'({1'b1, 1'b1, 3'd6, 32'd85}));
        be0 = bus_err_cnt;
        stb_cycles = 0;
        for (int i = 0; i < 20 && STB_O; i++) begin stb_cycles++; tick(); end
        check("to_stb_len", 64'(stb_cycles), 64'd4);
        for (int i = 0; i < 20 && !STB_O; i++) tick();
        check("to_bus_error", 64'(bus_err_cnt - be0), 64'd1);
        check("to_retry", 64'({STB_O, WE_O, ADR_O, DAT_O}), 64'({1'b1, 1'b1, 3'd6, 32'd85}));
        tick();
        check("pre_rst_cyc", 64'(CYC_O), 64'd1);
        #2 RST_I = 1'b0;
        #1 check("rst_async", 64'({CYC_O, STB_O, WE_O, ADR_O, DAT_O}), 64'd0);

        // Init with an acknowledging slave.
        tick(); tick();
        ack_en = 1'b1;
        base = log_q.size();
        RST_I = 1'b1;
        for (int i = 0; i < 50 && !init_done; i++) tick();
        check("init_done", 64'(init_done), 64'd1);
        tq.delete();
        for (int i = base; i < log_q.size(); i++) tq.push_back(log_q[i]);
        check("init_n", 64'(tq.size()), 64'd3);
        check("init_div", 64'(entry(tq, 0)), 64'({1'b1, 3'd6, 32'd85}));
        check("init_txctrl", 64'(entry(tq, 1)), 64'({1'b1, 3'd2, 32'd1}));
`ifdef UART_INITIATOR_RX_EN
        check("init_rxctrl", 64'(entry(tq, 2)), 64'({1'b1, 3'd3, 32'd1}));
`else
        check("init_rxctrl", 64'(entry(tq, 2)), 64'({1'b1, 3'd3, 32'd0}));
`endif

        // Single TX byte, FIFO not full.
        repeat (3) tick();
        base = log_q.size();
        rdy0 = tx_ready_cnt;
        tx_data = 8'h41;
        tx_valid = 1'b1;
        lat = 1;
        for (int i = 0; i < 40 && !tx_ready; i++) begin tick(); lat++; end
        tx_valid = 1'b0;
        check("tx1_ready", 64'(tx_ready), 64'd1);
`ifndef UART_INITIATOR_RX_EN
        check("tx1_latency", 64'(lat), 64'd6);
`endif
        repeat (5) tick();
        tq.delete();
        for (int i = base; i < log_q.size(); i++) if (log_q[i][34:32] == 3'd0) tq.push_back(log_q[i]);
        check("tx1_n", 64'(tq.size()), 64'd2);
        check("tx1_poll", 64'(entry(tq, 0)), 64'({1'b0, 3'd0, 32'd0}));
        check("tx1_write", 64'(entry(tq, 1)), 64'({1'b1, 3'd0, 32'h41}));
        check("tx1_ready_cnt", 64'(tx_ready_cnt - rdy0), 64'd1);

        // TX FIFO full for three polls.
        base = log_q.size();
        rdy0 = tx_ready_cnt;
        full_until = tx_polls + 3;
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        for (int i = 0; i < 100 && !tx_ready; i++) tick();
        tx_valid = 1'b0;
        repeat (5) tick();
        tq.delete();
        n_wr = 0;
        for (int i = base; i < log_q.size(); i++)
            if (log_q[i][34:32] == 3'd0) begin
                tq.push_back(log_q[i]);
                if (log_q[i][35]) n_wr++;
            end
        check("txf_n", 64'(tq.size()), 64'd5);
        check("txf_writes", 64'(n_wr), 64'd1);
        check("txf_last_poll", 64'(entry(tq, 3)), 64'({1'b0, 3'd0, 32'd0}));
        check("txf_write", 64'(entry(tq, 4)), 64'({1'b1, 3'd0, 32'hC3}));
        check("txf_ready_cnt", 64'(tx_ready_cnt - rdy0), 64'd1);

`ifdef UART_INITIATOR_RX_EN
        // RX byte held until handshaken.
        rx_word = 32'h0000_005A;
        for (int i = 0; i < 40 && !rx_valid; i++) tick();
        check("rx_valid", 64'(rx_valid), 64'd1);
        check("rx_data", 64'(rx_data), 64'h5A);
        rd0 = rx_reads;
        repeat (20) tick();
        check("rx_no_repoll", 64'(rx_reads - rd0), 64'd0);
        check("rx_hold", 64'({rx_valid, rx_data}), 64'({1'b1, 8'h5A}));
        rx_ready = 1'b1;
        rx_word = 32'h8000_0000;
        tick();
        rx_ready = 1'b0;
        check("rx_clear", 64'({rx_valid, rx_data}), 64'({1'b0, 8'h5A}));
        repeat (10) tick();
        check("rx_resume", 64'(rx_reads > rd0), 64'd1);
`endif

        // Continuous TX demand with the FIFO always full.
        base = log_q.size();
        full_until = tx_polls + 100000;
        tx_valid = 1'b1;
        repeat (60) tick();
        stop = log_q.size();
        tx_valid = 1'b0;
        n_rd = 0;
        n_wr = 0;
        alt_err = 0;
        last_adr = -1;
        for (int i = base; i < stop; i++)
            if (!log_q[i][35]) begin
                n_rd++;
                if (log_q[i][34:32] == 3'd1) n_wr++;
                if (int'(log_q[i][34:32]) == last_adr) alt_err++;
                last_adr = int'(log_q[i][34:32]);
            end
        check("alt_reads", 64'(n_rd >= 8), 64'd1);
`ifdef UART_INITIATOR_RX_EN
        check("alt_order", 64'(alt_err), 64'd0);
`else
        check("alt_no_rx", 64'(n_wr), 64'd0);
        check("rx_tied", 64'({rx_seen, rx_reads}), 64'd0);
`endif
        repeat (10) tick();
        check("idle_gap", 64'(gap_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
